// File: rtl/accum_cpu_core.sv
// Accumulator CPU core with embedded 4-function ALU, indirect load/store, signed skips
// and run/halt/resume control, driving a req/ready memory slave with wait-state support.
module accum_cpu_core #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  start,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  halted,
  output logic                  illegal
);

  localparam int OPR_W = DATA_WIDTH - 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = 2;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_HALT   = 4'h7;
  localparam logic [3:0] OP_SKIP   = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'h9;
  localparam logic [3:0] OP_CLEAR  = 4'hA;
  localparam logic [3:0] OP_LOADI  = 4'hB;
  localparam logic [3:0] OP_STOREI = 4'hC;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_INDIR, S_MEM, S_EXEC, S_HALT
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   pc, pc_nx, ea, ea_nx, addr_nx;
  logic [DATA_WIDTH-1:0]   ac, ac_nx, ir, ir_nx, mbr, mbr_nx, wdata_nx;
  logic                    req_nx, we_nx, illegal_nx;

  logic [3:0]              op;
  logic [ADDR_WIDTH-1:0]   opr, rd_addr, pc_dec;
  logic signed [DATA_WIDTH-1:0] ac_s;
  logic                    done, is_store;

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [3:0]            fn,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    case (fn)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      default: alu = b;
    endcase
  endfunction

  function automatic logic skip_taken(input logic [1:0]                 cond,
                                      input logic signed [DATA_WIDTH-1:0] v);
    case (cond)
      2'b00:   skip_taken = (v < 0);
      2'b01:   skip_taken = (v == 0);
      2'b10:   skip_taken = (v > 0);
      default: skip_taken = 1'b0;
    endcase
  endfunction

  assign op       = ir[DATA_WIDTH-1 -: 4];
  assign opr      = ADDR_WIDTH'(ir[OPR_W-1:0]);
  assign rd_addr  = ADDR_WIDTH'(mem_rdata);
  assign ac_s     = ac;
  assign done     = mem_req & mem_ready;
  assign is_store = (op == OP_STORE) || (op == OP_STOREI);

  always_comb begin
    pc_dec = pc + ADDR_ONE;
    if (op == OP_JUMP)
      pc_dec = opr;
    else if (op == OP_HALT)
      pc_dec = pc;
    else if (op == OP_SKIP && skip_taken(ir[DATA_WIDTH-5 -: 2], ac_s))
      pc_dec = pc + ADDR_TWO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ac        <= '0;
      ir        <= '0;
      ea        <= '0;
      mbr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      ac        <= ac_nx;
      ir        <= ir_nx;
      ea        <= ea_nx;
      mbr       <= mbr_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      illegal   <= illegal_nx;
    end
  end

  // Bus outputs are registered, so each state sets up the next request on its exit edge.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ac_nx      = ac;
    ir_nx      = ir;
    ea_nx      = ea;
    mbr_nx     = mbr;
    req_nx     = mem_req;
    we_nx      = mem_we;
    addr_nx    = mem_addr;
    wdata_nx   = mem_wdata;
    illegal_nx = illegal;

    case (state)
      S_FETCH: begin
        if (done) begin
          ir_nx    = mem_rdata;
          req_nx   = 1'b0;
          state_nx = S_DECODE;
        end else if (!mem_req && run) begin
          req_nx  = 1'b1;
          we_nx   = 1'b0;
          addr_nx = pc;
        end
      end

      S_DECODE: begin
        pc_nx = pc_dec;
        case (op)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STORE: begin
            ea_nx    = opr;
            req_nx   = 1'b1;
            we_nx    = (op == OP_STORE);
            addr_nx  = opr;
            wdata_nx = ac;
            state_nx = S_MEM;
          end
          OP_LOADI, OP_STOREI: begin
            req_nx   = 1'b1;
            we_nx    = 1'b0;
            addr_nx  = opr;
            state_nx = S_INDIR;
          end
          OP_HALT: state_nx = S_HALT;
          default: begin
            if (op == OP_CLEAR)
              ac_nx = '0;
            if (op >= 4'hD)
              illegal_nx = 1'b1;
            req_nx   = run;
            we_nx    = 1'b0;
            addr_nx  = pc_dec;
            state_nx = S_FETCH;
          end
        endcase
      end

      S_INDIR: begin
        if (done) begin
          ea_nx    = rd_addr;
          req_nx   = 1'b1;
          we_nx    = (op == OP_STOREI);
          addr_nx  = rd_addr;
          wdata_nx = ac;
          state_nx = S_MEM;
        end
      end

      S_MEM: begin
        addr_nx = ea;
        if (done) begin
          if (is_store) begin
            req_nx   = run;
            we_nx    = 1'b0;
            addr_nx  = pc;
            state_nx = S_FETCH;
          end else begin
            mbr_nx   = mem_rdata;
            req_nx   = 1'b0;
            we_nx    = 1'b0;
            state_nx = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        ac_nx    = alu(op, ac, mbr);
        req_nx   = run;
        we_nx    = 1'b0;
        addr_nx  = pc;
        state_nx = S_FETCH;
      end

      S_HALT: begin
        if (start) begin
          pc_nx    = pc + ADDR_ONE;
          req_nx   = run;
          we_nx    = 1'b0;
          addr_nx  = pc + ADDR_ONE;
          state_nx = S_FETCH;
        end
      end

      default: state_nx = S_FETCH;
    endcase
  end

  assign ac_out = ac;
  assign pc_out = pc;
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed bench for accum_cpu_core: behavioural RAM with programmable wait states,
// hand-computed expectations checked by immediate assertions.
module tb_accum_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        start = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [11:0] mem_addr, pc_out;
  logic [15:0] mem_wdata, mem_rdata, ac_out;
  logic        halted, illegal;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:4095];
  int          waits = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic        pl_we = 1'b0, pl_clr = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  int          stab_bad = 0, stab_chk = 0;
  logic        hv = 1'b0, hw = 1'b0;
  logic [11:0] ha = '0;
  logic [15:0] hd = '0;

  accum_cpu_core dut (
    .clk(clk), .rst_n(rst_n), .run(run), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ac_out(ac_out), .pc_out(pc_out), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign mem_ready = (wcnt >= waits);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (pl_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  // Bus must not move while a request is waiting for ready.
  always @(negedge clk) begin
    if (hv && rst_n) begin
      stab_chk <= stab_chk + 1;
      if (!(mem_req === 1'b1 && mem_addr === ha && mem_we === hw &&
            (hw === 1'b0 || mem_wdata === hd)))
        stab_bad <= stab_bad + 1;
    end
    hv <= rst_n && mem_req && !mem_ready;
    ha <= mem_addr;
    hw <= mem_we;
    hd <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int w);
    rst_n = 1'b0;
    run   = 1'b0;
    start = 1'b0;
    waits = w;
    @(negedge clk);
    pl_clr = 1'b1;
    @(posedge clk);
    #1 pl_clr = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic release_rst;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  task automatic wait_req(input logic [11:0] a, input bit match_addr, input bit need_we);
    int k = 0;
    @(negedge clk);
    while (!(mem_req === 1'b1 && (!match_addr || mem_addr === a) && (!need_we || mem_we === 1'b1))
           && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen_bound", {31'b0, mem_req}, 32'd1);
  endtask

  task automatic wait_halt(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (halted !== 1'b1 && n < max);
  endtask

  task automatic load_basic;
    poke(12'h100, 16'h1105);
    poke(12'h101, 16'h3106);
    poke(12'h102, 16'h2107);
    poke(12'h103, 16'h7000);
    poke(12'h105, 16'h0003);
    poke(12'h106, 16'h0004);
  endtask

  logic [15:0] sk_val [6] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
  logic [15:0] sk_ins [6] = '{16'h8000, 16'h8400, 16'h8400, 16'h8800, 16'h8800, 16'h8C00};
  logic [11:0] sk_pc  [6] = '{12'h103, 12'h103, 12'h102, 12'h103, 12'h102, 12'h102};

  initial begin
    int n, w0, s0, c0, rq;

    // Basic program, zero-wait slave
    do_reset(0);
    load_basic();
    chk("rst_mem_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr",  {20'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'h0);
    chk("rst_pc",        {20'b0, pc_out}, 32'h100);
    chk("rst_ac",        {16'b0, ac_out}, 32'h0);
    chk("rst_halted",    {31'b0, halted}, 32'd0);
    chk("rst_illegal",   {31'b0, illegal}, 32'd0);
    release_rst();
    wait_req(12'h100, 1'b1, 1'b0);
    wait_halt(200, n);
    chk("t1_cycles", n, 32'd13);
    chk("t1_m107",   {16'b0, mem[12'h107]}, 32'h7);
    chk("t1_ac",     {16'b0, ac_out}, 32'h7);
    chk("t1_halted", {31'b0, halted}, 32'd1);
    chk("t1_pc",     {20'b0, pc_out}, 32'h103);
    repeat (3) @(negedge clk);
    chk("t1_halt_noreq", {31'b0, mem_req}, 32'd0);

    // Same program, two wait states per access
    do_reset(2);
    load_basic();
    s0 = stab_bad;
    c0 = stab_chk;
    release_rst();
    wait_req(12'h100, 1'b1, 1'b0);
    wait_halt(300, n);
    chk("t2_cycles", n, 32'd27);
    chk("t2_m107",   {16'b0, mem[12'h107]}, 32'h7);
    chk("t2_ac",     {16'b0, ac_out}, 32'h7);
    chk("t2_pc",     {20'b0, pc_out}, 32'h103);
    chk("t2_stable_bad",  stab_bad - s0, 32'd0);
    chk("t2_wait_cycles", stab_chk - c0, 32'd14);

    // Indirect load then indirect store
    do_reset(0);
    poke(12'h100, 16'h9110);
    poke(12'h110, 16'hB120);
    poke(12'h111, 16'h1120);
    poke(12'h112, 16'hC120);
    poke(12'h113, 16'h7000);
    poke(12'h120, 16'h0130);
    poke(12'h130, 16'hBEEF);
    release_rst();
    wait_req(12'h110, 1'b1, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (ac_out !== 16'hBEEF && n < 50);
    chk("t3_loadi_cycles", n, 32'd5);
    wait_halt(200, n);
    chk("t3_m130", {16'b0, mem[12'h130]}, 32'h0130);
    chk("t3_ac",   {16'b0, ac_out}, 32'h0130);
    chk("t3_pc",   {20'b0, pc_out}, 32'h113);

    // Signed skip conditions
    for (int i = 0; i < 6; i++) begin
      do_reset(0);
      poke(12'h100, 16'h11F0);
      poke(12'h101, sk_ins[i]);
      poke(12'h102, 16'h7000);
      poke(12'h103, 16'h7000);
      poke(12'h1F0, sk_val[i]);
      release_rst();
      wait_halt(200, n);
      chk($sformatf("t4_skip_pc_%0d", i), {20'b0, pc_out}, {20'b0, sk_pc[i]});
    end

    // Reset asserted in the middle of a waited STORE
    do_reset(3);
    poke(12'h100, 16'h1105);
    poke(12'h101, 16'h2107);
    poke(12'h105, 16'h0003);
    poke(12'h107, 16'h5555);
    w0 = wr_cnt;
    release_rst();
    wait_req(12'h107, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("t5_req_drop", {31'b0, mem_req}, 32'd0);
    chk("t5_we_drop",  {31'b0, mem_we}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_write", wr_cnt - w0, 32'd0);
    chk("t5_m107",     {16'b0, mem[12'h107]}, 32'h5555);
    chk("t5_pc",       {20'b0, pc_out}, 32'h100);
    chk("t5_ac",       {16'b0, ac_out}, 32'h0);

    // run=0 stall, HALT/start resume, sticky illegal
    do_reset(0);
    load_basic();
    poke(12'h104, 16'hF000);
    poke(12'h108, 16'h7000);
    release_rst();
    wait_req(12'h105, 1'b1, 1'b0);
    run = 1'b0;
    rq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) rq++;
    end
    chk("t6_stall_noreq", rq, 32'd0);
    chk("t6_stall_ac",    {16'b0, ac_out}, 32'h3);
    chk("t6_stall_pc",    {20'b0, pc_out}, 32'h101);
    chk("t6_stall_halted", {31'b0, halted}, 32'd0);
    chk("t6_illegal_clr", {31'b0, illegal}, 32'd0);
    run = 1'b1;
    wait_halt(200, n);
    chk("t6_ac", {16'b0, ac_out}, 32'h7);
    chk("t6_pc", {20'b0, pc_out}, 32'h103);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_resumed", {31'b0, halted}, 32'd0);
    wait_halt(200, n);
    chk("t6_pc2",     {20'b0, pc_out}, 32'h108);
    chk("t6_illegal", {31'b0, illegal}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_illegal_sticky", {31'b0, illegal}, 32'd1);
    chk("t6_running",        {31'b0, halted}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
